tt_um_nibble_uart_tx: RTL and testbench
=======================================

Name: tt_um_nibble_uart_tx

Overview:
Tiny Tapeout tile that drives data out of the chip as a UART 8N1 stream, with optional even parity. A host writes two 4-bit nibbles on ui_in, low nibble first, using a strobe on uio_in[0]. The completed byte is serialized LSB-first on uio_out[2]. Status is returned on uo_out and on uio_out[3], so the tile is the output-direction counterpart of the team's nibble-input tiles.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535; the baud counter is clog2(CLKS_PER_BIT) bits wide.
PARITY_EN, 0, 1 inserts an even-parity bit between D7 and the stop bit.

Ports:
clk  in  1  clock; all state on the rising edge.
rst  in  1  asynchronous, active-high reset.
ena  in  1  clock enable; 0 freezes all state and outputs.
ui_in  in  4  data nibble; must be stable from the strobe rising edge until ready falls or lo_held toggles.
uio_in  in  4  [0] wr strobe (async level); [1] abort (async level); [3:2] unused.
uo_out  out  4  [0] ready, [1] lo_held, [2] overrun (sticky), [3] busy.
uio_out  out  4  [1:0] = 0; [2] txd; [3] frame_done (1-cycle pulse).
uio_oe  out  4  constant 4'b1100.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: txd=1, frame_done=0, ready=1, lo_held=0, overrun=0, busy=0, state=IDLE, counters=0, synchronizers=0.
- Input synchronization:
  - wr and abort each pass through a 2-flop synchronizer.
  - wr_evt = rising edge of synchronized wr, registered.
  - Latency from a wr pin edge to capture is 3 cycles.
  - abort_s is the synchronized level.
- FSM states: IDLE, START, DATA, PARITY, STOP. busy = (state != IDLE). ready = (state == IDLE).
- Loading in IDLE:
  - wr_evt with lo_held=0: lo <= ui_in, lo_held <= 1.
  - wr_evt with lo_held=1: byte <= {ui_in, lo}, lo_held <= 0, state <= START on the same edge.
  - txd goes 0 on the next cycle.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - txd = byte[bit_idx], each bit held CLKS_PER_BIT cycles.
  - After bit_idx=7: go to PARITY if PARITY_EN, else STOP.
- PARITY: txd = ^byte (even parity, so the total count of 1s including the parity bit is even), held CLKS_PER_BIT cycles.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - In the last cycle of STOP: frame_done=1 for exactly one cycle, and state <= IDLE.
- Total frame length is (10+PARITY_EN)*CLKS_PER_BIT cycles, start of the start bit to end of the stop bit.
- A new frame can start no earlier than the cycle after IDLE is re-entered, so the minimum idle gap is 1 cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; the bit advances when the counter reaches CLKS_PER_BIT-1.
  - The counter is cleared on every state entry.
- Overrun: wr_evt while busy sets overrun=1. The event is otherwise ignored: byte, lo and lo_held are unchanged and the frame is unaffected.
- Abort:
  - abort_s=1 forces state <= IDLE, txd <= 1, lo_held <= 0, overrun <= 0 and clears the counters.
  - While abort_s is held, wr_evt is ignored.
  - Abort mid-frame produces no frame_done.
- Simultaneous events:
  - abort_s beats wr_evt.
  - rst beats everything, asynchronously, at any point in a frame; txd returns to 1 immediately.
- ena=0: all registers, synchronizers included, hold their values; outputs hold; txd keeps its current level.

Decomposition:
- Package tt_nibble_tx_pkg holds:
  - the state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the constant UIO_OE_VAL = 4'b1100;
  - the constants DATA_BITS = 8 and STOP_BITS = 1;
  - uo_out bit-index constants.
- Sub-module tt_sync_edge:
  - 2-flop synchronizer plus a registered rising-edge detector, with ena and rst.
  - Outputs: level and edge.
  - Instantiated twice: wr (edge used) and abort (level used).

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0; write 0x5 then 0xA -> after the second capture, txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles). frame_done pulses once in cycle 40. ready returns to 1 the next cycle.
- PARITY_EN=1; send byte 0x07 -> parity bit txd=1 held 4 cycles before the stop bit; frame totals 44 cycles.
- Mid-DATA of a 0xA5 frame, a wr strobe -> overrun=1, the frame bits are unchanged, lo_held stays 0. After the frame, a new two-nibble write sends correctly and overrun stays 1 until abort.
- Assert abort at bit_idx=3 -> within 3 cycles txd=1, ready=1, overrun=0, no frame_done. The next 0x3C write transmits cleanly.
- Assert rst mid-STOP and mid-load (lo_held=1) -> all outputs immediately at reset values. The first subsequent nibble is treated as the low nibble.
- ena=0 for 7 cycles mid-DATA -> txd is frozen and the frame is stretched by exactly 7 cycles. The bit sequence is identical to the ena=1 case.

Source files
------------

// File: rtl/tt_nibble_tx_pkg.sv
// Shared types and constants for the nibble-loaded UART transmitter tile.
package tt_nibble_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [3:0] UIO_OE_VAL = 4'b1100;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   // uo_out bit positions
   localparam int unsigned UO_READY   = 0;
   localparam int unsigned UO_LO_HELD = 1;
   localparam int unsigned UO_OVERRUN = 2;
   localparam int unsigned UO_BUSY    = 3;

   // uio_out bit positions
   localparam int unsigned UIO_TXD        = 2;
   localparam int unsigned UIO_FRAME_DONE = 3;

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge detector.
module tt_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_ena,
   input  logic i_d,
   output logic o_level,
   output logic o_edge
);

   logic r_meta;
   logic r_sync;
   logic r_edge;

   // Edge is taken across the two stages so it lines up with the synchronized level rising.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_edge <= 1'b0;
      end else if (i_ena) begin
         r_meta <= i_d;
         r_sync <= r_meta;
         r_edge <= r_meta & ~r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_edge  = r_edge;

endmodule

// File: rtl/tt_um_nibble_uart_tx.sv
// Tiny Tapeout tile: two nibble writes assemble a byte that is sent as UART 8N1 (optional even parity).
module tt_um_nibble_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [3:0] ui_in,
   input  logic [3:0] uio_in,
   output logic [3:0] uo_out,
   output logic [3:0] uio_out,
   output logic [3:0] uio_oe
);
   import tt_nibble_tx_pkg::*;

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   logic w_wr_evt;
   logic w_abort;
   logic w_wr_level_unused;
   logic w_abort_edge_unused;
   logic w_unused;

   state_t           r_state,   w_state_n;
   logic [CNT_W-1:0] r_cnt,     w_cnt_n;
   logic [BIT_W-1:0] r_bit,     w_bit_n;
   logic [3:0]       r_lo,      w_lo_n;
   logic             r_lo_held, w_lo_held_n;
   logic [7:0]       r_byte,    w_byte_n;
   logic             r_ovr,     w_ovr_n;
   logic             r_txd,     w_txd_n;
   logic             r_done,    w_done_n;
   logic             r_ready,   w_ready_n;
   logic             r_busy,    w_busy_n;
   logic             w_cnt_last;
   logic             w_tx_bit;

   assign w_unused = &{1'b0, uio_in[3:2]};

   tt_sync_edge u_sync_wr (
      .clk     (clk),
      .rst     (rst),
      .i_ena   (ena),
      .i_d     (uio_in[0]),
      .o_level (w_wr_level_unused),
      .o_edge  (w_wr_evt)
   );

   tt_sync_edge u_sync_abort (
      .clk     (clk),
      .rst     (rst),
      .i_ena   (ena),
      .i_d     (uio_in[1]),
      .o_level (w_abort),
      .o_edge  (w_abort_edge_unused)
   );

   assign w_cnt_last = (r_cnt == CNT_LAST);

   // State register plus output register stage; ena freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_lo      <= '0;
         r_lo_held <= 1'b0;
         r_byte    <= '0;
         r_ovr     <= 1'b0;
         r_txd     <= 1'b1;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
      end else if (ena) begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_bit     <= w_bit_n;
         r_lo      <= w_lo_n;
         r_lo_held <= w_lo_held_n;
         r_byte    <= w_byte_n;
         r_ovr     <= w_ovr_n;
         r_txd     <= w_txd_n;
         r_done    <= w_done_n;
         r_ready   <= w_ready_n;
         r_busy    <= w_busy_n;
      end
   end

   // Next-state, loading and overrun logic; outputs are a registered image of the current state.
   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_bit_n     = r_bit;
      w_lo_n      = r_lo;
      w_lo_held_n = r_lo_held;
      w_byte_n    = r_byte;
      w_ovr_n     = r_ovr;
      w_tx_bit    = 1'b1;

      case (r_state)
         START:   w_tx_bit = 1'b0;
         DATA:    w_tx_bit = r_byte[r_bit];
         PARITY:  w_tx_bit = ^r_byte;
         default: w_tx_bit = 1'b1;
      endcase

      w_txd_n   = w_abort | w_tx_bit;
      w_done_n  = ~w_abort & (r_state == STOP) & w_cnt_last & (r_bit == STOP_LAST);
      w_ready_n = w_abort | (r_state == IDLE);
      w_busy_n  = ~w_abort & (r_state != IDLE);

      if (w_abort) begin
         w_state_n   = IDLE;
         w_cnt_n     = '0;
         w_bit_n     = '0;
         w_lo_held_n = 1'b0;
         w_ovr_n     = 1'b0;
      end else begin
         if (w_wr_evt && (r_state != IDLE)) begin
            w_ovr_n = 1'b1;
         end
         case (r_state)
            IDLE: begin
               w_cnt_n = '0;
               if (w_wr_evt) begin
                  if (!r_lo_held) begin
                     w_lo_n      = ui_in;
                     w_lo_held_n = 1'b1;
                  end else begin
                     w_byte_n    = {ui_in, r_lo};
                     w_lo_held_n = 1'b0;
                     w_state_n   = START;
                  end
               end
            end
            START: begin
               if (w_cnt_last) begin
                  w_state_n = DATA;
                  w_cnt_n   = '0;
                  w_bit_n   = '0;
               end else begin
                  w_cnt_n = r_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (w_cnt_last) begin
                  w_cnt_n = '0;
                  if (r_bit == DATA_LAST) begin
                     w_bit_n   = '0;
                     w_state_n = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     w_bit_n = r_bit + BIT_W'(1);
                  end
               end else begin
                  w_cnt_n = r_cnt + CNT_W'(1);
               end
            end
            PARITY: begin
               if (w_cnt_last) begin
                  w_state_n = STOP;
                  w_cnt_n   = '0;
                  w_bit_n   = '0;
               end else begin
                  w_cnt_n = r_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (w_cnt_last) begin
                  w_cnt_n = '0;
                  if (r_bit == STOP_LAST) begin
                     w_bit_n   = '0;
                     w_state_n = IDLE;
                  end else begin
                     w_bit_n = r_bit + BIT_W'(1);
                  end
               end else begin
                  w_cnt_n = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_n = IDLE;
               w_cnt_n   = '0;
               w_bit_n   = '0;
            end
         endcase
      end
   end

   // Pack status and line outputs onto the tile pins.
   always_comb begin
      uo_out                  = '0;
      uo_out[UO_READY]        = r_ready;
      uo_out[UO_LO_HELD]      = r_lo_held;
      uo_out[UO_OVERRUN]      = r_ovr;
      uo_out[UO_BUSY]         = r_busy;
      uio_out                 = '0;
      uio_out[UIO_TXD]        = r_txd;
      uio_out[UIO_FRAME_DONE] = r_done;
   end

   assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_nibble_uart_tx.sv
// Bench for the nibble UART transmitter: two instances (no parity / even parity) against a frame-level model.
module tb_tt_um_nibble_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena;
   logic [3:0] ui_in;
   logic [3:0] uio_in;
   logic [3:0] uo0, uio0, oe0;
   logic [3:0] uo1, uio1, oe1;

   int checks = 0;
   int errors = 0;

   tt_um_nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
      .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo0), .uio_out(uio0), .uio_oe(oe0)
   );

   tt_um_nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
      .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   // m_t: enabled clocks since the capturing edge of the high nibble, -1 when no frame.
   int         m_t [2];
   int         m_n [2];
   logic [10:0] m_bits [2];
   logic       m_lo_held [2];
   logic       m_ovr [2];
   logic [3:0] m_lo [2];
   logic [3:0] wr_h, ab_h;

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_t[p] = -1; m_n[p] = 10 + p; m_bits[p] = '1;
         m_lo_held[p] = 1'b0; m_ovr[p] = 1'b0; m_lo[p] = '0;
      end
      wr_h = '0; ab_h = '0;
   endtask

   task automatic model_step();
      logic evt, ab, busy_before;
      logic [7:0] b;
      wr_h = {wr_h[2:0], uio_in[0]};
      ab_h = {ab_h[2:0], uio_in[1]};
      evt  = wr_h[2] & ~wr_h[3];   // pin edge reaches the core three clocks later
      ab   = ab_h[2];
      for (int p = 0; p < 2; p++) begin
         busy_before = (m_t[p] >= 0) && (m_t[p] < m_n[p] * CPB);
         if (m_t[p] >= 0 && m_t[p] < 1000) m_t[p]++;
         if (ab) begin
            m_t[p] = -1; m_lo_held[p] = 1'b0; m_ovr[p] = 1'b0;
         end else if (evt) begin
            if (busy_before) m_ovr[p] = 1'b1;
            else if (!m_lo_held[p]) begin
               m_lo[p] = ui_in; m_lo_held[p] = 1'b1;
            end else begin
               b = {ui_in, m_lo[p]};
               m_lo_held[p] = 1'b0;
               m_t[p] = 0;
               m_bits[p] = '1;
               m_bits[p][0] = 1'b0;
               for (int i = 0; i < 8; i++) m_bits[p][1+i] = b[i];
               if (p == 1) m_bits[p][9] = ^b;
            end
         end
      end
   endtask

   function automatic logic [11:0] m_expect(input int p);
      int nc;
      logic txd, done, busy;
      nc = m_n[p] * CPB;
      txd = 1'b1; busy = 1'b0;
      if (m_t[p] >= 1 && m_t[p] <= nc) begin
         txd  = m_bits[p][(m_t[p] - 1) / CPB];
         busy = 1'b1;
      end
      done = (m_t[p] == nc);
      return {4'b1100, done, txd, 2'b00, busy, m_ovr[p], m_lo_held[p], ~busy};
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else if (ena) model_step();
      end
   end

   // Every-cycle compare of all pins against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("cycle_dut0", 32'({oe0, uio0, uo0}), 32'(m_expect(0)));
         chk("cycle_dut1", 32'({oe1, uio1, uo1}), 32'(m_expect(1)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_wr(input logic [3:0] nib);
      ui_in = nib; uio_in[0] = 1'b1;
      repeat (4) tick();
      uio_in[0] = 1'b0;
      repeat (3) tick();
   endtask

   // Load a byte; returns just after the high-nibble capture edge.
   task automatic load_byte(input logic [7:0] b);
      pulse_wr(b[3:0]);
      ui_in = b[7:4]; uio_in[0] = 1'b1;
      repeat (3) tick();
      uio_in[0] = 1'b0;
   endtask

   task automatic send_rec(input logic [7:0] b, input int ovr_at, input int ab_at, input int ena_at,
                           output logic [9:0] v0, output logic [10:0] v1,
                           output int d0, output int d1, output int r0);
      int eff, k;
      logic en_prev;
      load_byte(b);
      v0 = '1; v1 = '1; d0 = -1; d1 = -1; r0 = -1; eff = 0;
      for (int n = 1; n <= 60; n++) begin
         if (n == ovr_at)     begin ui_in = 4'hF; uio_in[0] = 1'b1; end
         if (n == ovr_at + 4) uio_in[0] = 1'b0;
         if (n == ab_at)      uio_in[1] = 1'b1;
         if (n == ab_at + 4)  uio_in[1] = 1'b0;
         if (n == ena_at)     ena = 1'b0;
         if (n == ena_at + 7) ena = 1'b1;
         en_prev = ena;
         tick();
         if (en_prev) begin
            eff++;
            if ((eff - 1) % CPB == 1) begin
               k = (eff - 1) / CPB;
               if (k < 10) v0[k] = uio0[2];
               if (k < 11) v1[k] = uio1[2];
            end
         end
         if (n == ab_at + 2) begin
            chk("abort_uo0", 32'(uo0), 32'(4'b0001));
            chk("abort_uio0", 32'(uio0), 32'(4'b0100));
         end
         if (d0 < 0 && uio0[3]) d0 = n;
         if (d1 < 0 && uio1[3]) d1 = n;
         if (r0 < 0 && uo0[0]) r0 = n;
      end
   endtask

   logic [9:0]  v0;
   logic [10:0] v1;
   int          d0, d1, r0;

   initial begin
      ena = 1'b1; ui_in = '0; uio_in = '0;
      repeat (3) tick();
      chk("rst_uo0", 32'(uo0), 32'(4'b0001));
      chk("rst_uio0", 32'(uio0), 32'(4'b0100));
      chk("rst_oe0", 32'(oe0), 32'(4'b1100));
      rst = 1'b0;
      repeat (2) tick();

      // 0x5 then 0xA -> byte 0xA5
      send_rec(8'hA5, -100, -100, -100, v0, v1, d0, d1, r0);
      chk("a5_bits0", 32'(v0), 32'(10'b1101001010));
      chk("a5_bits1", 32'(v1), 32'(11'b10101001010));
      chk("a5_done0", 32'(d0), 32'(40));
      chk("a5_ready0", 32'(r0), 32'(41));
      chk("a5_done1", 32'(d1), 32'(44));

      // even parity on 0x07 is 1
      send_rec(8'h07, -100, -100, -100, v0, v1, d0, d1, r0);
      chk("x07_bits0", 32'(v0), 32'(10'b1000001110));
      chk("x07_bits1", 32'(v1), 32'(11'b11000001110));
      chk("x07_parity", 32'(v1[9]), 32'(1));
      chk("x07_done1", 32'(d1), 32'(44));

      // write strobe mid-DATA sets overrun, frame untouched
      send_rec(8'hA5, 10, -100, -100, v0, v1, d0, d1, r0);
      chk("ovr_bits0", 32'(v0), 32'(10'b1101001010));
      chk("ovr_done0", 32'(d0), 32'(40));
      chk("ovr_uo0", 32'(uo0), 32'(4'b0101));
      chk("ovr_uo1", 32'(uo1), 32'(4'b0101));

      send_rec(8'h81, -100, -100, -100, v0, v1, d0, d1, r0);
      chk("x81_bits0", 32'(v0), 32'(10'b1100000010));
      chk("x81_sticky", 32'(uo0), 32'(4'b0101));

      // abort during data bit 3
      send_rec(8'hA5, -100, 17, -100, v0, v1, d0, d1, r0);
      chk("abort_nodone0", 32'(d0), 32'(-1));
      chk("abort_nodone1", 32'(d1), 32'(-1));
      chk("abort_final_uo0", 32'(uo0), 32'(4'b0001));

      send_rec(8'h3C, -100, -100, -100, v0, v1, d0, d1, r0);
      chk("x3c_bits0", 32'(v0), 32'(10'b1001111000));
      chk("x3c_done0", 32'(d0), 32'(40));

      // ena low for 7 clocks mid-DATA stretches the frame by 7
      send_rec(8'hA5, -100, -100, 14, v0, v1, d0, d1, r0);
      chk("ena_bits0", 32'(v0), 32'(10'b1101001010));
      chk("ena_done0", 32'(d0), 32'(47));
      chk("ena_done1", 32'(d1), 32'(51));

      // reset during the stop bit
      load_byte(8'h5A);
      repeat (38) tick();
      rst = 1'b1;
      #1;
      chk("rst_stop_uo0", 32'(uo0), 32'(4'b0001));
      chk("rst_stop_uio0", 32'(uio0), 32'(4'b0100));
      chk("rst_stop_uo1", 32'(uo1), 32'(4'b0001));
      chk("rst_stop_uio1", 32'(uio1), 32'(4'b0100));
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // reset with a low nibble held
      pulse_wr(4'h9);
      chk("load_held_uo0", 32'(uo0), 32'(4'b0011));
      rst = 1'b1;
      #1;
      chk("rst_load_uo0", 32'(uo0), 32'(4'b0001));
      tick();
      rst = 1'b0;
      repeat (2) tick();

      send_rec(8'h6E, -100, -100, -100, v0, v1, d0, d1, r0);
      chk("x6e_bits0", 32'(v0), 32'(10'b1011011100));
      chk("x6e_done0", 32'(d0), 32'(40));

      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

endmodule
